// File: rtl/alu_defs.sv
// Shared ALU operation codes, BIST state encodings and the table record
// used by the ALU self-test sequencer.
package alu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } bist_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] exp_result;
        logic        exp_zero;
    } bist_vec_t;

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed self-test vector table: index -> operands, operation and expected
// ALU response. Out-of-range indices read back as all zeros.
module alu_bist_rom
    import alu_defs::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    output bist_vec_t        vec
);

    // Table lookup
    always_comb begin
        vec = '0;
        case (idx)
            IDX_W'(0): vec = '{a: 32'd10,         b: 32'd15,         ctrl: ALU_ADD,
                               exp_result: 32'd25,         exp_zero: 1'b0};
            IDX_W'(1): vec = '{a: 32'd20,         b: 32'd5,          ctrl: ALU_SUB,
                               exp_result: 32'd15,         exp_zero: 1'b0};
            IDX_W'(2): vec = '{a: 32'd30,         b: 32'd30,         ctrl: ALU_SUB,
                               exp_result: 32'd0,          exp_zero: 1'b1};
            IDX_W'(3): vec = '{a: 32'hF0F0_F0F0,  b: 32'h0F0F_0F0F,  ctrl: ALU_AND,
                               exp_result: 32'h0000_0000,  exp_zero: 1'b1};
            IDX_W'(4): vec = '{a: 32'hF000_0000,  b: 32'h0F00_0000,  ctrl: ALU_OR,
                               exp_result: 32'hFF00_0000,  exp_zero: 1'b0};
            IDX_W'(5): vec = '{a: 32'd5,          b: 32'd10,         ctrl: ALU_SLT,
                               exp_result: 32'd1,          exp_zero: 1'b0};
            IDX_W'(6): vec = '{a: 32'd15,         b: 32'd10,         ctrl: ALU_SLT,
                               exp_result: 32'd0,          exp_zero: 1'b1};
            default:   vec = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: plays the vector table onto the ALU
// inputs, two cycles per vector, and accumulates pass/fail status.
module alu_bist
    import alu_defs::*;
#(
    parameter int NUM_VECTORS = 7,
    parameter int IDX_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [31:0]       A,
    output logic [31:0]       B,
    output logic [2:0]        ALUControl,
    input  logic [31:0]       ALUResult,
    input  logic              Zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [IDX_W-1:0]  fail_idx,
    output logic              fail_seen
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      exp_result_q, exp_result_d;
    logic             exp_zero_q, exp_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic             fail_seen_q, fail_seen_d;

    logic [IDX_W-1:0] rom_idx_s;
    bist_vec_t        rom_vec_s;
    logic             mismatch_s;

    // Expected values are latched with the operands, so a single ROM port
    // can already point at the next entry while the current one is checked.
    assign rom_idx_s  = (state_q == ST_CHECK) ? (idx_q + IDX_W'(1)) : IDX_W'(0);
    assign mismatch_s = (ALUResult != exp_result_q) || (Zero != exp_zero_q);

    alu_bist_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx (rom_idx_s),
        .vec (rom_vec_s)
    );

    // Next-state, operand sequencing and status update
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        exp_result_d = exp_result_q;
        exp_zero_d   = exp_zero_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_idx_d   = fail_idx_q;
        fail_seen_d  = fail_seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    idx_d        = '0;
                    a_d          = rom_vec_s.a;
                    b_d          = rom_vec_s.b;
                    ctrl_d       = rom_vec_s.ctrl;
                    exp_result_d = rom_vec_s.exp_result;
                    exp_zero_d   = rom_vec_s.exp_zero;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = 8'd0;
                    fail_idx_d   = '0;
                    fail_seen_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (!fail_seen_q) begin
                        fail_idx_d  = idx_q;
                        fail_seen_d = 1'b1;
                    end else begin
                        fail_idx_d  = fail_idx_q;
                    end
                end else begin
                    err_count_d = err_count_q;
                end
                // pass must reflect the last vector's outcome too
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == 8'd0);
                end else begin
                    state_d      = ST_APPLY;
                    idx_d        = idx_q + IDX_W'(1);
                    a_d          = rom_vec_s.a;
                    b_d          = rom_vec_s.b;
                    ctrl_d       = rom_vec_s.ctrl;
                    exp_result_d = rom_vec_s.exp_result;
                    exp_zero_d   = rom_vec_s.exp_zero;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            ctrl_q       <= 3'b000;
            exp_result_q <= 32'd0;
            exp_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 8'd0;
            fail_idx_q   <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            exp_result_q <= exp_result_d;
            exp_zero_q   <= exp_zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_idx_q   <= fail_idx_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign ALUControl = ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_idx   = fail_idx_q;
    assign fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist with a behavioural ALU that can be
// switched into fault modes (SLT inverted, Zero stuck at 0).
module tb_alu_bist;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a_s, b_s, alu_result;
    logic [2:0]  ctrl_s;
    logic        alu_zero;
    logic        busy, done, pass, fail_seen;
    logic [7:0]  err_count;
    logic [2:0]  fail_idx;
    int          fault_mode;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
    } vec_t;

    typedef struct {
        int         fault;
        logic [7:0] err;
        logic [2:0] fidx;
        logic       fseen;
        logic       pass_e;
    } run_t;

    vec_t vt[7];
    run_t runs[3];

    alu_bist #(.NUM_VECTORS(7), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (a_s),
        .B          (b_s),
        .ALUControl (ctrl_s),
        .ALUResult  (alu_result),
        .Zero       (alu_zero),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_idx   (fail_idx),
        .fail_seen  (fail_seen)
    );

    always #5 clk = ~clk;

    // Reference ALU with optional injected faults
    always_comb begin
        alu_result = 32'd0;
        case (ctrl_s)
            3'b000:  alu_result = a_s & b_s;
            3'b001:  alu_result = a_s | b_s;
            3'b010:  alu_result = a_s + b_s;
            3'b110:  alu_result = a_s - b_s;
            3'b111:  alu_result = ($signed(a_s) < $signed(b_s)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        if (fault_mode == 1 && ctrl_s == 3'b111) alu_result = {31'd0, ~alu_result[0]};
        alu_zero = (alu_result == 32'd0);
        if (fault_mode == 2) alu_zero = 1'b0;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ops(input int e);
        int k;
        k = e / 2;
        chk($sformatf("ops_e%0d", e), {busy, done, a_s, b_s, ctrl_s},
            {1'b1, 1'b0, vt[k].a, vt[k].b, vt[k].c});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Pulse start, follow the run with the operand monitor, return latency
    task automatic run_pulse(output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        chk_ops(0);
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (lat < 14) chk_ops(lat);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {a_s, b_s, ctrl_s, busy, done, pass, err_count, fail_idx, fail_seen},
            {32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0});
    endtask

    initial begin
        int lat;

        vt[0] = '{32'd10,        32'd15,        3'b010};
        vt[1] = '{32'd20,        32'd5,         3'b110};
        vt[2] = '{32'd30,        32'd30,        3'b110};
        vt[3] = '{32'hF0F0F0F0,  32'h0F0F0F0F,  3'b000};
        vt[4] = '{32'hF0000000,  32'h0F000000,  3'b001};
        vt[5] = '{32'd5,         32'd10,        3'b111};
        vt[6] = '{32'd15,        32'd10,        3'b111};

        runs[0] = '{0, 8'd0, 3'd0, 1'b0, 1'b1};
        runs[1] = '{1, 8'd2, 3'd5, 1'b1, 1'b0};
        runs[2] = '{2, 8'd3, 3'd2, 1'b1, 1'b0};

        fault_mode = 0;
        do_reset();
        chk_all_zero("reset_state");

        for (int i = 0; i < 3; i++) begin
            do_reset();
            fault_mode = runs[i].fault;
            run_pulse(lat);
            chk($sformatf("latency_run%0d", i), lat, 14);
            chk($sformatf("status_run%0d", i),
                {busy, done, pass, err_count, fail_seen},
                {1'b0, 1'b1, runs[i].pass_e, runs[i].err, runs[i].fseen});
            if (runs[i].fseen) chk($sformatf("fail_idx_run%0d", i), fail_idx, runs[i].fidx);
            chk($sformatf("hold_last_run%0d", i), {a_s, b_s, ctrl_s}, {vt[6].a, vt[6].b, vt[6].c});
            step();
            chk($sformatf("done_stays_run%0d", i), {busy, done, err_count},
                {1'b0, 1'b1, runs[i].err});
        end

        // start held high: no restart while busy, one-cycle done, then restart
        do_reset();
        fault_mode = 1;
        start = 1'b1;
        step();
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("hold_latency", lat, 14);
        chk("hold_done", {busy, done, err_count}, {1'b0, 1'b1, 8'd2});
        step();
        chk("hold_restart", {busy, done, err_count, fail_seen, a_s, ctrl_s},
            {1'b1, 1'b0, 8'd0, 1'b0, vt[0].a, vt[0].c});
        start = 1'b0;

        // reset five cycles into a run, then a clean full run
        fault_mode = 0;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 5; j++) step();
        chk("midrun_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("midrun_reset");
        step();
        chk_all_zero("idle_after_reset");
        run_pulse(lat);
        chk("rerun_latency", lat, 14);
        chk("rerun_status", {done, pass, err_count, fail_seen}, {1'b1, 1'b1, 8'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer that drives the single-cycle datapath ALU from the operand/control side. It plays a fixed table of operations on the ALU's A, B and ALUControl inputs and checks ALUResult and Zero against stored expected values. It reports pass/fail, an error count and the index of the first failing vector. It sits beside the ALU in the datapath. A mux outside this block selects between the normal datapath and BIST operands while `busy` is high.

## Interface
- NUM_VECTORS, 7: number of table entries; must match the table in alu_bist_rom.
- IDX_W, 3: index width; must satisfy ceil(log2(NUM_VECTORS)) <= IDX_W.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start/restart request, sampled in IDLE and DONE only.
- A  out  32  ALU operand A, registered.
- B  out  32  ALU operand B, registered.
- ALUControl  out  3  ALU operation select, registered.
- ALUResult  in  32  result from ALU (combinational).
- Zero  in  1  zero flag from ALU.
- busy  out  1  high in APPLY/CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  8  mismatching vectors this run, saturating at 255.
- fail_idx  out  IDX_W  index of first mismatching vector; valid when fail_seen.
- fail_seen  out  1  at least one mismatch this run.

## Operation
- Every output resets to 0: A, B, ALUControl=000, busy, done, pass, err_count, fail_idx, fail_seen. The state resets to IDLE and idx to 0.
- The FSM has four states: IDLE, APPLY, CHECK, DONE.
- IDLE, start=1:
  - Load A/B/ALUControl from table entry 0.
  - Clear idx, err_count, fail_seen, fail_idx and pass.
  - Go to APPLY.
- APPLY: hold operands for one settle cycle, then go to CHECK.
- CHECK:
  - Compare ALUResult against exp_result and Zero against exp_zero. Any inequality is a mismatch.
  - On mismatch: increment err_count (saturating). If fail_seen=0, set fail_idx=idx and fail_seen=1.
  - If idx == NUM_VECTORS-1, go to DONE. Otherwise increment idx, load the next table entry onto A/B/ALUControl, and go to APPLY.
- DONE:
  - done=1 and pass=(err_count==0).
  - Operands hold the last vector.
  - start=1 restarts exactly as from IDLE (done drops on the same edge).
- start is ignored while busy.
- Reset mid-run aborts immediately to the reset values. No partial result is retained.
- Table contents (A, B, ctrl -> result, zero):
  - 0: 10, 15, ADD -> 25, 0.
  - 1: 20, 5, SUB -> 15, 0.
  - 2: 30, 30, SUB -> 0, 1.
  - 3: F0F0F0F0, 0F0F0F0F, AND -> 00000000, 1.
  - 4: F0000000, 0F000000, OR -> FF000000, 0.
  - 5: 5, 10, SLT -> 1, 0.
  - 6: 15, 10, SLT -> 0, 1.

## Timing
- Each vector takes 2 cycles: APPLY, then CHECK. The comparison is sampled at the CHECK-exit edge.
- Let t0 be the edge at which start is sampled high. Vector k is checked at edge t0+2k+2, and done rises after edge t0+2·NUM_VECTORS (t0+14 for the default).
- busy is high from t0 until the edge where done rises. busy and done are never high together.
- A/B/ALUControl change only on edges leaving IDLE/DONE or CHECK. They are stable for the full APPLY and CHECK cycles.
- ALUResult/Zero must settle within one clock of the operands changing. The ALU is combinational and is not registered.

## Structure
- Shared package/header alu_defs:
  - ALUControl codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - BIST state encodings.
- Sub-module alu_bist_rom: combinational lookup, idx -> {A, B, ctrl, exp_result, exp_zero}. An out-of-range idx returns all zeros.
- The top level holds the FSM, idx counter, comparator and status registers.

## Test plan
- Reset, then start pulse, with the real ALU attached -> done rises 14 cycles after the start edge; pass=1, err_count=0, fail_seen=0.
- Faulty-ALU model with SLT result inverted -> err_count=2, fail_idx=5, fail_seen=1, pass=0.
- Faulty-ALU model with Zero stuck at 0 -> err_count=3 (vectors 2, 3, 6), fail_idx=2.
- Hold start high throughout the run -> no restart while busy. The run restarts on the edge after done rises; done is high for exactly 1 cycle, then busy, with err_count cleared.
- Assert reset at cycle 5 of a run -> next cycle all outputs are 0 and the state is IDLE. A subsequent start completes a full 14-cycle run.
- Per-vector monitor -> A/B/ALUControl show the 7 table entries in order, each stable for 2 cycles.
